// File: rtl/mem_stage_if.sv
// Bundle of the execute-side, data-memory and writeback signals of the memory stage.
// Pure wiring: no state, no latency.
// Backpressure travels as mem_busy (toward execute) and dm_ack (from memory).
interface mem_stage_if;
    // execute -> stage
    logic        ex_valid;
    logic [1:0]  ex_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_dreg;
    logic        mem_busy;
    // stage <-> data memory
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    // stage -> writeback
    logic [31:0] data_out;
    logic [4:0]  dreg_out;
    logic        stall_out;
    logic        mem_err;

    // The memory stage itself.
    modport slave (
        input  ex_valid, ex_op, ex_addr, ex_wdata, ex_dreg, dm_ack, dm_rdata,
        output mem_busy, dm_req, dm_we, dm_addr, dm_wdata,
        output data_out, dreg_out, stall_out, mem_err
    );

    // The surroundings (execute, data memory, writeback) as one agent.
    modport master (
        output ex_valid, ex_op, ex_addr, ex_wdata, ex_dreg, dm_ack, dm_rdata,
        input  mem_busy, dm_req, dm_we, dm_addr, dm_wdata,
        input  data_out, dreg_out, stall_out, mem_err
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: pass ALU result or do one word load/store over req/ack.
// Latency: pass 1 cycle; load/store 1 issue cycle + wait until dm_ack (min 2 cycles).
// Backpressure: mem_busy holds execute while an access is outstanding; optional abort via MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clock,
    input  logic        reset,
    mem_stage_if.slave  bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    state_t      state;
    state_t      state_nxt;

    // Destination and kind of the outstanding access, captured at issue.
    logic [4:0]  cap_dreg;
    logic        cap_load;

    // Next values of the registered outputs and captures.
    logic        req_nxt;
    logic        we_nxt;
    logic [31:0] addr_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] data_nxt;
    logic [4:0]  dreg_nxt;
    logic        stall_nxt;
    logic        err_nxt;
    logic [4:0]  cap_dreg_nxt;
    logic        cap_load_nxt;

    logic        is_mem_op;
    logic        issue_ok;
    logic        issue_bad;
    logic        tmo;

    assign is_mem_op = (bus.ex_op == OP_LOAD) || (bus.ex_op == OP_STORE);
    assign issue_ok  = bus.ex_valid && is_mem_op && (bus.ex_addr[1:0] == 2'b00);
    // Reserved opcode, or a load/store that is not word aligned.
    assign issue_bad = bus.ex_valid && !issue_ok && (bus.ex_op != OP_PASS);

    assign bus.mem_busy = (state == ACCESS);

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt;

    // Last waiting cycle is the one where the count has reached TIMEOUT-1,
    // so dm_req stays up for exactly TIMEOUT cycles without an ack.
    assign tmo = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // Wait counter: parked at zero in IDLE, counts ACCESS cycles without ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (!bus.dm_ack) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    // Without the timeout the stage waits for dm_ack indefinitely.
    assign tmo = 1'b0;
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^{32'(TIMEOUT), 32'(CNT_W)};
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; ack takes priority over timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue_ok) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.dm_ack || tmo) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: next values for the bus, writeback and capture registers.
    always_comb begin
        req_nxt      = bus.dm_req;
        we_nxt       = bus.dm_we;
        addr_nxt     = bus.dm_addr;
        wdata_nxt    = bus.dm_wdata;
        data_nxt     = bus.data_out;
        dreg_nxt     = bus.dreg_out;
        stall_nxt    = 1'b1;
        err_nxt      = 1'b0;
        cap_dreg_nxt = cap_dreg;
        cap_load_nxt = cap_load;
        case (state)
            IDLE: begin
                if (bus.ex_valid && (bus.ex_op == OP_PASS)) begin
                    data_nxt  = bus.ex_addr;
                    dreg_nxt  = bus.ex_dreg;
                    // r0 is hardwired zero: never let writeback touch it.
                    stall_nxt = (bus.ex_dreg == 5'd0);
                end else if (issue_ok) begin
                    req_nxt      = 1'b1;
                    we_nxt       = (bus.ex_op == OP_STORE);
                    addr_nxt     = bus.ex_addr;
                    wdata_nxt    = bus.ex_wdata;
                    cap_dreg_nxt = bus.ex_dreg;
                    cap_load_nxt = (bus.ex_op == OP_LOAD);
                end else if (issue_bad) begin
                    err_nxt = 1'b1;
                end
            end
            ACCESS: begin
                if (bus.dm_ack) begin
                    req_nxt = 1'b0;
                    if (cap_load) begin
                        data_nxt  = bus.dm_rdata;
                        dreg_nxt  = cap_dreg;
                        stall_nxt = (cap_dreg == 5'd0);
                    end
                end else if (tmo) begin
                    req_nxt = 1'b0;
                    err_nxt = 1'b1;
                end
            end
            default: begin
                req_nxt = 1'b0;
            end
        endcase
    end

    // Output and capture registers; reset drops any pending access silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.dm_req    <= 1'b0;
            bus.dm_we     <= 1'b0;
            bus.dm_addr   <= '0;
            bus.dm_wdata  <= '0;
            bus.data_out  <= '0;
            bus.dreg_out  <= '0;
            bus.stall_out <= 1'b1;
            bus.mem_err   <= 1'b0;
            cap_dreg      <= '0;
            cap_load      <= 1'b0;
        end else begin
            bus.dm_req    <= req_nxt;
            bus.dm_we     <= we_nxt;
            bus.dm_addr   <= addr_nxt;
            bus.dm_wdata  <= wdata_nxt;
            bus.data_out  <= data_nxt;
            bus.dreg_out  <= dreg_nxt;
            bus.stall_out <= stall_nxt;
            bus.mem_err   <= err_nxt;
            cap_dreg      <= cap_dreg_nxt;
            cap_load      <= cap_load_nxt;
        end
    end

endmodule
